// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - shared 32-bit instruction format definitions (opcodes, field positions, loader states)
//   Contents: opcode constants OP_LDI..OP_SHR, OP_MAX (highest legal opcode),
//   LSB positions of every packed field, loader FSM state enum.
package isa_pkg;

  localparam logic [5:0] OP_LDI       = 6'b000000;
  localparam logic [5:0] OP_MOV       = 6'b000001;
  localparam logic [5:0] OP_LD        = 6'b000010;
  localparam logic [5:0] OP_ST        = 6'b000011;
  localparam logic [5:0] OP_ALU_FIRST = 6'b000100;
  localparam logic [5:0] OP_SHR       = 6'b010000;
  localparam logic [5:0] OP_MAX       = OP_SHR;

  // LSB position of each field inside the 32-bit word
  localparam int OP_LSB       = 26;
  localparam int RDST2_LSB    = 21;
  localparam int RDST1_LSB    = 16;
  localparam int IMM16_LSB    = 0;
  localparam int LD_MADDR_LSB = 0;
  localparam int ST_MADDR_LSB = 18;
  localparam int RSRC2_LSB    = 5;   // ALU position
  localparam int MOV_SRC_LSB  = 0;   // MOV/ST place rsrc2 in the low bits
  localparam int RSRC1_LSB    = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_FULL  = 3'd4
  } load_state_t;

endpackage

// File: rtl/instr_encoder_loader_if.sv
// rtl/instr_encoder_loader_if.sv - field-bundle input handshake and instruction memory write port
//   master: program source / memory model side (drives bundles and imem_ack)
//   slave : encoder side (drives in_ready and the imem write request)
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic              in_last;
  logic [5:0]        op;
  logic [4:0]        rdst2;
  logic [4:0]        rdst1;
  logic [4:0]        rsrc2;
  logic [4:0]        rsrc1;
  logic [15:0]       imm16;
  logic [7:0]        maddr;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_ack;

  modport master (
    output in_valid, in_last, op, rdst2, rdst1, rsrc2, rsrc1, imm16, maddr, imem_ack,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_last, op, rdst2, rdst1, rsrc2, rsrc1, imm16, maddr, imem_ack,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_pack.sv
// rtl/instr_pack.sv - combinational field packer: decoded fields -> {legal, 32-bit word}
//   in : op[5:0], rdst2, rdst1, rsrc2, rsrc1 [4:0], imm16[15:0], maddr[7:0]
//   out: legal (opcode within the defined set), word[31:0] (unused bits zero)
import isa_pkg::*;

module instr_pack (
  input  logic [5:0]  op,
  input  logic [4:0]  rdst2,
  input  logic [4:0]  rdst1,
  input  logic [4:0]  rsrc2,
  input  logic [4:0]  rsrc1,
  input  logic [15:0] imm16,
  input  logic [7:0]  maddr,
  output logic        legal,
  output logic [31:0] word
);

  always_comb begin
    legal = 1'b1;
    word  = 32'(op) << OP_LSB;
    if (op == OP_LDI) begin
      word = word | (32'(rdst2) << RDST2_LSB) | (32'(imm16) << IMM16_LSB);
    end else if (op == OP_MOV) begin
      word = word | (32'(rdst2) << RDST2_LSB) | (32'(rsrc2) << MOV_SRC_LSB);
    end else if (op == OP_LD) begin
      word = word | (32'(rdst2) << RDST2_LSB) | (32'(maddr) << LD_MADDR_LSB);
    end else if (op == OP_ST) begin
      word = word | (32'(maddr) << ST_MADDR_LSB) | (32'(rsrc2) << MOV_SRC_LSB);
    end else if (op >= OP_ALU_FIRST && op <= OP_MAX) begin
      word = word | (32'(rdst2) << RDST2_LSB) | (32'(rdst1) << RDST1_LSB)
                  | (32'(rsrc2) << RSRC2_LSB) | (32'(rsrc1) << RSRC1_LSB);
    end else begin
      legal = 1'b0;
      word  = 32'd0;
    end
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// rtl/instr_encoder_loader.sv - packs field bundles and writes them to instruction memory at consecutive addresses
//   clk, rst (async active-high), start (session pulse)
//   bus (slave): in_valid/in_ready/in_last + fields in; imem_we/imem_addr/imem_wdata out, imem_ack in
//   busy, done (pulse), full (level until next start), instr_count, err_illegal (pulse), illegal_cnt
import isa_pkg::*;

module instr_encoder_loader #(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  instr_encoder_loader_if.slave  bus,
  output logic                   busy,
  output logic                   done,
  output logic                   full,
  output logic [ADDR_W:0]        instr_count,
  output logic                   err_illegal,
  output logic [7:0]             illegal_cnt
);

  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   LIMIT = (ADDR_W+1)'(DEPTH);

  load_state_t       state, state_n;
  logic              legal;
  logic [31:0]       word;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              last_q;     // in_last of the bundle currently being written
  logic              take;       // bundle accepted this cycle
  logic              ack_wr;     // write completes this cycle
  logic [ADDR_W:0]   count_inc;
  logic              hit_limit;

  instr_pack u_pack (
    .op    (bus.op),
    .rdst2 (bus.rdst2),
    .rdst1 (bus.rdst1),
    .rsrc2 (bus.rsrc2),
    .rsrc1 (bus.rsrc1),
    .imm16 (bus.imm16),
    .maddr (bus.maddr),
    .legal (legal),
    .word  (word)
  );

  assign take      = (state == ST_LOAD) && bus.in_valid;
  assign ack_wr    = (state == ST_WRITE) && bus.imem_ack;
  assign count_inc = instr_count + 1'b1;
  assign hit_limit = (count_inc == LIMIT);

  // Status and write request come straight from the state register, so an
  // async reset drops imem_we in the same instant it clears the state.
  assign bus.in_ready   = (state == ST_LOAD);
  assign bus.imem_we    = (state == ST_WRITE);
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign busy           = (state == ST_LOAD) || (state == ST_WRITE);
  assign done           = (state == ST_DONE) || (state == ST_FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (start) state_n = ST_LOAD;
      ST_LOAD: begin
        if (take) begin
          if (legal)            state_n = ST_WRITE;
          else if (bus.in_last) state_n = ST_DONE;
        end
      end
      ST_WRITE: begin
        // the depth limit wins over in_last of the final bundle
        if (ack_wr) begin
          if (hit_limit)   state_n = ST_FULL;
          else if (last_q) state_n = ST_DONE;
          else             state_n = ST_LOAD;
        end
      end
      ST_DONE:  state_n = ST_IDLE;
      ST_FULL:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= BASE;
      wdata_q     <= 32'd0;
      last_q      <= 1'b0;
      instr_count <= '0;
      illegal_cnt <= 8'd0;
      err_illegal <= 1'b0;
      full        <= 1'b0;
    end else begin
      err_illegal <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            addr_q      <= BASE;
            instr_count <= '0;
            illegal_cnt <= 8'd0;
            full        <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (take) begin
            if (legal) begin
              wdata_q <= word;
              last_q  <= bus.in_last;
            end else begin
              err_illegal <= 1'b1;
              if (illegal_cnt != 8'hFF) illegal_cnt <= illegal_cnt + 8'd1;
            end
          end
        end
        ST_WRITE: begin
          if (ack_wr) begin
            instr_count <= count_inc;
            addr_q      <= addr_q + 1'b1;
            if (hit_limit) full <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
